// File: rtl/gpu_frame_sequencer.sv
// gpu_frame_sequencer: Avalon-MM host that walks the voxel GPU through camera load, batched raycast, rasterize and pixel write-out.
module gpu_frame_sequencer #(
  parameter int          H_RESOLUTION = 320,
  parameter int          V_RESOLUTION = 240,
  parameter int          NUM_SHADERS  = 320,
  parameter logic [31:0] FB_BASE      = 32'h0800_0000,
  parameter int          IRQ_TIMEOUT  = 65535
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [479:0] cam_words,
  input  logic [31:0]  voxel_data,
  input  logic         voxel_valid,
  input  logic         voxel_last,
  output logic         voxel_ready,
  output logic [7:0]   m_address,
  output logic         m_write,
  output logic [31:0]  m_writedata,
  output logic         m_read,
  input  logic [31:0]  m_readdata,
  input  logic         m_waitrequest,
  input  logic         gpu_irq,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [1:0]   error_code
);
  localparam int HV = H_RESOLUTION * V_RESOLUTION;
  localparam int COL_BITS = $clog2(H_RESOLUTION);
  localparam int CW = COL_BITS > 0 ? COL_BITS : 1;
  localparam int TW = $clog2(IRQ_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, CAM, COORD, WAIT, ACK, VOX, PIX, RECOVER} state_t;

  state_t      state_q, state_d, ret_q, ret_d;
  logic        m_write_q, m_write_d, m_read_q, m_read_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  cam_idx_q, cam_idx_d;
  logic [TW-1:0] wcnt_q, wcnt_d;
  logic [31:0] batch_q, batch_d, pcnt_q, pcnt_d, row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic        last_q, last_d, busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [1:0]  error_code_q, error_code_d;

  logic        bus_busy, xfer_done, issue, rd, pix_last;
  logic [7:0]  a;
  logic [31:0] wd, pix_addr, next_batch;

  assign bus_busy   = m_write_q | m_read_q;
  assign xfer_done  = bus_busy & ~m_waitrequest;
  assign pix_addr   = FB_BASE + (row_q << (COL_BITS + 1)) + (32'(col_q) << 1);
  assign pix_last   = (pcnt_q == 32'(NUM_SHADERS - 1)) || (batch_q + pcnt_q == 32'(HV - 1));
  assign next_batch = batch_q + 32'(NUM_SHADERS);

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    m_write_d    = m_write_q;
    m_read_d     = m_read_q;
    addr_d       = addr_q;
    data_d       = data_q;
    cam_idx_d    = cam_idx_q;
    wcnt_d       = wcnt_q;
    batch_d      = batch_q;
    pcnt_d       = pcnt_q;
    row_d        = row_q;
    col_d        = col_q;
    last_d       = last_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = error_q;
    error_code_d = error_code_q;
    voxel_ready  = 1'b0;
    issue        = 1'b0;
    rd           = 1'b0;
    a            = '0;
    wd           = '0;
    case (state_q)
      IDLE: if (start) begin
        busy_d       = 1'b1;
        error_d      = 1'b0;
        error_code_d = '0;
        batch_d      = '0;
        pcnt_d       = '0;
        row_d        = '0;
        col_d        = '0;
        cam_idx_d    = '0;
        state_d      = CAM;
      end
      CAM: begin
        issue = 1'b1;
        a     = 8'h10 + 8'(cam_idx_q);
        wd    = cam_words[32*cam_idx_q +: 32];
        if (xfer_done) begin
          cam_idx_d = cam_idx_q + 4'd1;
          if (cam_idx_q == 4'd14) state_d = COORD;
        end
      end
      COORD: begin
        issue = 1'b1;
        a     = 8'h03;
        wd    = batch_q;
        if (xfer_done) begin
          state_d = WAIT;
          ret_d   = VOX;
          wcnt_d  = '0;
        end
      end
      WAIT: begin
        if (gpu_irq) state_d = ACK;
        else if (wcnt_q == TW'(IRQ_TIMEOUT - 1)) begin
          error_code_d = 2'd2;
          state_d      = RECOVER;
        end else wcnt_d = wcnt_q + 1'b1;
      end
      ACK: begin
        issue = 1'b1;
        rd    = 1'b1;
        a     = 8'h0f;
        if (xfer_done) begin
          if (m_readdata == 32'd2) begin
            error_code_d = 2'd1;
            state_d      = RECOVER;
          end else if (ret_q == IDLE) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else state_d = ret_q;
        end
      end
      VOX: begin
        voxel_ready = ~bus_busy;
        issue       = voxel_valid;
        wd          = voxel_data;
        if (!bus_busy && voxel_valid) last_d = voxel_last;
        if (xfer_done) begin
          state_d = WAIT;
          wcnt_d  = '0;
          ret_d   = last_q ? PIX : VOX;
        end
      end
      PIX: begin
        issue = 1'b1;
        a     = 8'h02;
        wd    = pix_addr;
        if (xfer_done) begin
          // row/col track the global pixel index across batches, so no divider is needed
          col_d   = (col_q == CW'(H_RESOLUTION - 1)) ? '0 : col_q + 1'b1;
          row_d   = (col_q == CW'(H_RESOLUTION - 1)) ? row_q + 32'd1 : row_q;
          pcnt_d  = pix_last ? '0 : pcnt_q + 32'd1;
          batch_d = pix_last ? next_batch : batch_q;
          ret_d   = !pix_last ? PIX : (next_batch < 32'(HV)) ? COORD : IDLE;
          wcnt_d  = '0;
          state_d = WAIT;
        end
      end
      RECOVER: begin
        issue = 1'b1;
        a     = 8'h0f;
        wd    = 32'd1;
        if (xfer_done) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!bus_busy && issue) begin
      m_write_d = ~rd;
      m_read_d  = rd;
      addr_d    = a;
      data_d    = wd;
    end
    // dropping the strobe on completion guarantees an idle cycle before the next transfer
    if (xfer_done) begin
      m_write_d = 1'b0;
      m_read_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ret_q        <= IDLE;
      m_write_q    <= 1'b0;
      m_read_q     <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      cam_idx_q    <= '0;
      wcnt_q       <= '0;
      batch_q      <= '0;
      pcnt_q       <= '0;
      row_q        <= '0;
      col_q        <= '0;
      last_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      error_code_q <= '0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      m_write_q    <= m_write_d;
      m_read_q     <= m_read_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      cam_idx_q    <= cam_idx_d;
      wcnt_q       <= wcnt_d;
      batch_q      <= batch_d;
      pcnt_q       <= pcnt_d;
      row_q        <= row_d;
      col_q        <= col_d;
      last_q       <= last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      error_code_q <= error_code_d;
    end
  end

  assign m_write     = m_write_q;
  assign m_read      = m_read_q;
  assign m_address   = addr_q;
  assign m_writedata = data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign error_code  = error_code_q;
endmodule

// File: tb/tb_gpu_frame_sequencer.sv
// tb_gpu_frame_sequencer: GPU slave model with write scoreboard, covering full frames, stalls, errors, timeout and mid-frame reset.
module tb_gpu_frame_sequencer;
  localparam int          H  = 5;
  localparam int          V  = 2;
  localparam int          NS = 4;
  localparam int          TO = 10;
  localparam logic [31:0] FB = 32'h100;
  localparam int          CB = $clog2(H);

  logic         clock = 0, reset = 1, start = 0;
  logic [479:0] cam_words;
  logic [31:0]  voxel_data, m_writedata, m_readdata;
  logic         voxel_valid, voxel_last, voxel_ready;
  logic [7:0]   m_address;
  logic         m_write, m_read, m_waitrequest;
  logic         gpu_irq = 0;
  logic         busy, done, error;
  logic [1:0]   error_code;

  int total = 0, bad = 0;
  logic [39:0] exp_q[$];
  logic [32:0] vox_mem[16];
  logic [3:0]  vrd = 0, vwr = 0;
  int wait_n = 0, stall_cnt = 0, pend = 0;
  bit irq_en = 1, err_inject = 0;
  logic [7:0] last_cmd = 0;
  int cyc = 0, reads = 0, dones = 0, pix_seen = 0, t_coord = 0, t_rec = 0;

  always #5 clock = ~clock;

  assign voxel_valid   = vrd != vwr;
  assign voxel_data    = vox_mem[vrd][31:0];
  assign voxel_last    = vox_mem[vrd][32];
  assign m_waitrequest = (m_write || m_read) && stall_cnt < wait_n;
  assign m_readdata    = (err_inject && last_cmd == 8'h00) ? 32'd2 : 32'd0;

  gpu_frame_sequencer #(
    .H_RESOLUTION(H), .V_RESOLUTION(V), .NUM_SHADERS(NS), .FB_BASE(FB), .IRQ_TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .cam_words(cam_words),
    .voxel_data(voxel_data), .voxel_valid(voxel_valid), .voxel_last(voxel_last),
    .voxel_ready(voxel_ready), .m_address(m_address), .m_write(m_write),
    .m_writedata(m_writedata), .m_read(m_read), .m_readdata(m_readdata),
    .m_waitrequest(m_waitrequest), .gpu_irq(gpu_irq), .busy(busy), .done(done),
    .error(error), .error_code(error_code)
  );

  function automatic logic [31:0] cw(int k);
    return 32'hC0DE_0000 + 32'(k) * 32'h101;
  endfunction

  task automatic slave();
    logic w, r, st, cmp, pop, stall_prev, done_prev, pw, pr;
    logic [7:0] a, pa;
    logic [31:0] d, pd;
    logic [39:0] e;
    stall_prev = 0; done_prev = 0; pw = 0; pr = 0; pa = 0; pd = 0;
    forever begin
      @(posedge clock);
      w = m_write; r = m_read; st = m_waitrequest; a = m_address; d = m_writedata;
      cmp = (w || r) && !st;
      pop = voxel_valid && voxel_ready;
      cyc++;
      if (done) dones++;
      if (stall_prev) begin
        total++;
        if ({a, d, w, r} !== {pa, pd, pw, pr}) begin
          bad++;
          $display("FAIL bus_stable: got %h/%h w%b r%b required %h/%h w%b r%b", a, d, w, r, pa, pd, pw, pr);
        end
      end
      if (done_prev) begin
        total++;
        if (w || r) begin bad++; $display("FAIL bus_gap: got strobe w%b r%b required idle", w, r); end
      end
      if (w && r) begin total++; bad++; $display("FAIL rw_both: got read and write together required one"); end
      #1;
      if (pop) vrd++;
      stall_cnt = ((w || r) && st) ? stall_cnt + 1 : 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0 && irq_en) gpu_irq = 1;
      end
      if (cmp && w) begin
        if (a <= 8'h03) begin pend = 3; last_cmd = a; end
        if (a == 8'h03 && d == 0) t_coord = cyc;
        if (a == 8'h0f) t_rec = cyc;
        if (a == 8'h02) pix_seen++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL write_extra: got %h<-%h required no write", a, d);
        end else begin
          e = exp_q.pop_front();
          if ({a, d} !== e) begin bad++; $display("FAIL write_seq: got %h<-%h required %h<-%h", a, d, e[39:32], e[31:0]); end
        end
      end
      if (cmp && r) begin
        reads++;
        gpu_irq = 0;
        total++;
        if (a !== 8'h0f) begin bad++; $display("FAIL status_addr: got %h required 0f", a); end
      end
      stall_prev = (w || r) && st; pa = a; pd = d; pw = w; pr = r; done_prev = cmp;
    end
  endtask

  task automatic push_cam();
    for (int k = 0; k < 15; k++) exp_q.push_back({8'(16 + k), cw(k)});
  endtask

  task automatic push_frame();
    int nv;
    logic [31:0] v;
    push_cam();
    for (int b = 0; b < H * V; b += NS) begin
      exp_q.push_back({8'h03, 32'(b)});
      nv = (b == 0) ? 2 : 1;
      for (int j = 0; j < nv; j++) begin
        v = 32'hA000_0000 + 32'(b * 16 + j);
        vox_mem[vwr] = {j == nv - 1, v};
        vwr++;
        exp_q.push_back({8'h00, v});
      end
      for (int p = b; p < b + NS && p < H * V; p++)
        exp_q.push_back({8'h02, FB + (32'(p / H) << (CB + 1)) + 32'((p % H) * 2)});
    end
  endtask

  task automatic do_reset();
    reset = 1;
    start = 0;
    @(negedge clock);
    exp_q.delete();
    vrd = 0; vwr = 0; pend = 0; gpu_irq = 0; stall_cnt = 0;
    @(negedge clock);
    reset = 0;
    @(negedge clock);
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1;
    @(negedge clock);
    start = 0;
  endtask

  task automatic wait_idle(string nm);
    int n = 0;
    while (busy && n < 5000) begin @(negedge clock); n++; end
    total++;
    if (busy) begin bad++; $display("FAIL %s_idle: got busy=1 after %0d cycles required 0", nm, n); end
    repeat (3) @(negedge clock);
  endtask

  task automatic check_end(string nm, int d0, int exp_done, logic exp_err, logic [1:0] exp_code);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL %s_pending: got %0d writes missing required 0", nm, exp_q.size()); end
    total++;
    if (dones - d0 != exp_done) begin bad++; $display("FAIL %s_done: got %0d pulses required %0d", nm, dones - d0, exp_done); end
    total++;
    if ({busy, error, error_code} !== {1'b0, exp_err, exp_code})
      begin bad++; $display("FAIL %s_flags: got busy%b err%b code%0d required busy0 err%b code%0d", nm, busy, error, error_code, exp_err, exp_code); end
  endtask

  task automatic test_reset();
    @(negedge clock);
    total++;
    if ({busy, done, error, error_code, voxel_ready} !== 6'b0)
      begin bad++; $display("FAIL reset_ctrl: got %b required 000000", {busy, done, error, error_code, voxel_ready}); end
    total++;
    if ({m_write, m_read, m_address, m_writedata} !== 42'b0)
      begin bad++; $display("FAIL reset_bus: got w%b r%b %h %h required all zero", m_write, m_read, m_address, m_writedata); end
    do_reset();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_release: got busy=%b required 0", busy); end
  endtask

  task automatic test_frame(int wn, string nm);
    int d0, r0;
    wait_n = wn;
    vrd = 0; vwr = 0;
    push_frame();
    d0 = dones; r0 = reads;
    pulse_start();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL %s_busy: got %b required 1", nm, busy); end
    wait_idle(nm);
    check_end(nm, d0, 1, 1'b0, 2'd0);
    total++;
    if (reads - r0 != 17) begin bad++; $display("FAIL %s_reads: got %0d required 17", nm, reads - r0); end
    wait_n = 0;
  endtask

  task automatic test_error();
    int d0;
    err_inject = 1;
    vrd = 0; vwr = 0;
    vox_mem[0] = {1'b1, 32'hBEEF_0001};
    vwr = 1;
    push_cam();
    exp_q.push_back({8'h03, 32'd0});
    exp_q.push_back({8'h00, 32'hBEEF_0001});
    exp_q.push_back({8'h0f, 32'd1});
    d0 = dones;
    pulse_start();
    wait_idle("error");
    check_end("error", d0, 0, 1'b1, 2'd1);
    err_inject = 0;
    vrd = 0; vwr = 0;
    push_frame();
    d0 = dones;
    pulse_start();
    total++;
    if ({busy, error, error_code} !== 4'b1000)
      begin bad++; $display("FAIL error_clear: got busy%b err%b code%0d required busy1 err0 code0", busy, error, error_code); end
    wait_idle("error_replay");
    check_end("error_replay", d0, 1, 1'b0, 2'd0);
  endtask

  task automatic test_timeout();
    int d0;
    irq_en = 0;
    vrd = 0; vwr = 0;
    push_cam();
    exp_q.push_back({8'h03, 32'd0});
    exp_q.push_back({8'h0f, 32'd1});
    d0 = dones;
    pulse_start();
    wait_idle("timeout");
    check_end("timeout", d0, 0, 1'b1, 2'd2);
    // command cycle, then TO cycles in WAIT and one idle bus cycle before the recovery write
    total++;
    if (t_rec - t_coord != TO + 2) begin bad++; $display("FAIL timeout_cycles: got %0d required %0d", t_rec - t_coord, TO + 2); end
    irq_en = 1;
  endtask

  task automatic test_reset_mid();
    int d0, r0, p0, n;
    vrd = 0; vwr = 0;
    push_frame();
    p0 = pix_seen;
    pulse_start();
    n = 0;
    while (pix_seen == p0 && n < 5000) begin @(negedge clock); n++; end
    total++;
    if (pix_seen == p0) begin bad++; $display("FAIL mid_reach_pix: got no pixel write required one"); end
    do_reset();
    total++;
    if ({busy, m_write, m_read} !== 3'b0) begin bad++; $display("FAIL mid_abort: got busy%b w%b r%b required 000", busy, m_write, m_read); end
    push_frame();
    d0 = dones; r0 = reads;
    pulse_start();
    repeat (20) @(negedge clock);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b required 1", busy); end
    pulse_start();
    wait_idle("mid_replay");
    check_end("mid_replay", d0, 1, 1'b0, 2'd0);
    total++;
    if (reads - r0 != 17) begin bad++; $display("FAIL mid_reads: got %0d required 17", reads - r0); end
  endtask

  initial begin
    for (int k = 0; k < 15; k++) cam_words[32*k +: 32] = cw(k);
    fork slave(); join_none
    test_reset();
    test_frame(0, "frame");
    test_frame(5, "stall");
    test_error();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
